// File: rtl/interleaver_pkg.sv
// Shared definitions for the interleaver receive deframer.
//  state_e        : deframer FSM states (IDLE, RECV)
//  SHORT_LEN_DEF  : default short frame length in bits
//  LONG_LEN_DEF   : default long frame length in bits
//  BIT_CNT_W      : width of the per-frame bit counter
package interleaver_pkg;

  typedef enum logic [0:0] {
    IDLE,
    RECV
  } state_e;

  localparam int unsigned SHORT_LEN_DEF = 1056;
  localparam int unsigned LONG_LEN_DEF  = 6144;
  localparam int unsigned BIT_CNT_W     = 13;

endpackage

// File: rtl/rx_byte_fifo.sv
// Synchronous byte FIFO with full/empty flags and simultaneous push/pop.
// Ports:
//  clock, reset   : rising-edge clock, synchronous active-high reset
//  push, push_data: write request and byte; accepted when not full or when popping
//  pop            : read request; head advances when not empty
//  pop_data       : head byte (0 while empty)
//  full, empty    : occupancy flags
module rx_byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit: equal index with differing MSB means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the head slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? 8'h00 : mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/interleaver_rx_deframer.sv
// Receive deframer for the interleaver test link: packs the serial stream MSB-first into
// bytes, queues them in a small FIFO and reports frame completion, overflow and framing errors.
// Optional feature macro: RX_CHECKSUM_EN adds checksum[7:0], XOR of all bytes of the last frame.
// Ports:
//  clock, reset            : rising-edge clock, synchronous active-high reset
//  data_in                 : serial data bit
//  flag_long_in            : long-frame select, sampled on the start cycle only
//  look_now_in             : frame-start strobe, data_in on this cycle is bit 0
//  byte_out, byte_valid    : FIFO head byte and non-empty flag
//  byte_ready              : consumer accept
//  frame_done              : one-cycle pulse after the final bit
//  overflow, framing_err   : sticky error flags
//  bit_count               : bits received in the current frame
module interleaver_rx_deframer
  import interleaver_pkg::*;
#(
  parameter int unsigned SHORT_LEN  = SHORT_LEN_DEF,
  parameter int unsigned LONG_LEN   = LONG_LEN_DEF,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 data_in,
  input  logic                 flag_long_in,
  input  logic                 look_now_in,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 framing_err,
`ifdef RX_CHECKSUM_EN
  output logic [7:0]           checksum,
`endif
  output logic [BIT_CNT_W-1:0] bit_count
);

  state_e               state_q;
  logic [6:0]           shift_q;
  logic [BIT_CNT_W-1:0] len_q;
  logic [BIT_CNT_W-1:0] bit_count_next;
  logic [7:0]           new_byte;
  logic                 in_recv;
  logic                 byte_done;
  logic                 last_bit;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign in_recv        = (state_q == RECV);
  assign bit_count_next = bit_count + 1'b1;
  assign new_byte       = {shift_q, data_in};
  // A strobe in RECV restarts the frame, so the current bit never completes the old byte.
  assign byte_done      = in_recv && !look_now_in && (bit_count[2:0] == 3'd7);
  assign last_bit       = in_recv && !look_now_in && (bit_count_next == len_q);
  assign byte_valid     = !fifo_empty;
  assign pop            = byte_valid && byte_ready;

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (byte_done),
    .push_data (new_byte),
    .pop       (pop),
    .pop_data  (byte_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      len_q       <= '0;
      bit_count   <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      frame_done <= last_bit;
      if (byte_done && fifo_full && !pop) overflow <= 1'b1;
      if (look_now_in) begin
        if (in_recv) framing_err <= 1'b1;
        len_q     <= flag_long_in ? BIT_CNT_W'(LONG_LEN) : BIT_CNT_W'(SHORT_LEN);
        shift_q   <= {6'b0, data_in};
        bit_count <= BIT_CNT_W'(1);
        state_q   <= RECV;
      end else if (in_recv) begin
        shift_q   <= new_byte[6:0];
        bit_count <= bit_count_next;
        if (last_bit) state_q <= IDLE;
      end
    end
  end

`ifdef RX_CHECKSUM_EN
  logic [7:0] acc_q;

  // Running XOR covers dropped bytes too; the output only updates on the final byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      checksum <= '0;
    end else if (look_now_in) begin
      acc_q    <= '0;
      checksum <= '0;
    end else if (byte_done) begin
      acc_q <= acc_q ^ new_byte;
      if (last_bit) checksum <= acc_q ^ new_byte;
    end
  end
`endif

endmodule

// File: tb/tb_interleaver_rx_deframer.sv
module tb_interleaver_rx_deframer;

  logic        clock = 1'b0;
  logic        reset;
  logic        data_in;
  logic        flag_long_in;
  logic        look_now_in;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        frame_done;
  logic        overflow;
  logic        framing_err;
  logic [12:0] bit_count;
`ifdef RX_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int fd0;
  logic [7:0] exp_q [$];

  always #5 clock = ~clock;

  interleaver_rx_deframer #(
    .SHORT_LEN  (1056),
    .LONG_LEN   (6144),
    .FIFO_DEPTH (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .flag_long_in (flag_long_in),
    .look_now_in  (look_now_in),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .framing_err  (framing_err),
`ifdef RX_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .bit_count    (bit_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gen_byte(input int mode, input int idx);
    logic [7:0] b;
    case (mode)
      0:       b = 8'(idx);
      1:       b = (idx % 2 == 0) ? 8'hA5 : 8'h5A;
      default: b = ((idx % 2 == 0) ? 8'hA5 : 8'h5A) ^ ((idx == 5) ? 8'hFF : 8'h00);
    endcase
    return b;
  endfunction

  // Scoreboard consumer: every accepted byte must match the queue head.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_done) fd_cnt++;
      if (byte_valid && byte_ready) begin
        check_val("pop_has_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_val("pop_byte", byte_out, exp_q.pop_front());
      end
    end
  end

  // Drives nbits of a frame starting at bit 0; byte_ready rises at bit ready_bit;
  // only the first keep completed bytes are expected to survive.
  task automatic send_frame(input bit long_f, input int nbits, input int mode,
                            input int ready_bit, input int keep);
    int kept = 0;
    logic [7:0] b;
    for (int i = 0; i < nbits; i++) begin
      b            = gen_byte(mode, i / 8);
      data_in      = b[7 - (i % 8)];
      look_now_in  = (i == 0);
      flag_long_in = (i == 0) ? long_f : 1'($urandom_range(0, 1));
      byte_ready   = (i >= ready_bit);
      if ((i % 8 == 7) && (kept < keep)) begin
        exp_q.push_back(b);
        kept++;
      end
      @(posedge clock);
      #1;
    end
    look_now_in = 1'b0;
    data_in     = 1'b0;
  endtask

  task automatic check_frame_end(input int len);
    check_val("frame_done_pulse", frame_done, 1);
    check_val("bit_count_end", bit_count, len);
    @(posedge clock);
    #1;
    check_val("frame_done_single", frame_done, 0);
  endtask

  task automatic drain();
    int t = 0;
    byte_ready = 1'b1;
    while ((exp_q.size() != 0 || byte_valid) && t < 3000) begin
      @(posedge clock);
      #1;
      t++;
    end
    check_val("drain_queue_empty", exp_q.size(), 0);
    check_val("drain_valid_low", byte_valid, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    data_in      = 1'b0;
    flag_long_in = 1'b0;
    look_now_in  = 1'b0;
    byte_ready   = 1'b0;

    // Reset state and quiet idle.
    repeat (10) begin
      @(negedge clock);
      check_val("reset_outputs",
                {byte_out, byte_valid, frame_done, overflow, framing_err, bit_count}, 0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (20) begin
      @(negedge clock);
      check_val("idle_no_valid", byte_valid, 0);
    end
    @(posedge clock);
    #1;

    // Short frame, consumer always ready.
    fd0 = fd_cnt;
    send_frame(1'b0, 1056, 0, 0, 1000);
    check_frame_end(1056);
    drain();
    check_val("short_fd_count", fd_cnt - fd0, 1);
    check_val("short_no_overflow", overflow, 0);

    // Long frame.
    fd0 = fd_cnt;
    send_frame(1'b1, 6144, 0, 0, 1000);
    check_frame_end(6144);
    drain();
    check_val("long_fd_count", fd_cnt - fd0, 1);
    check_val("long_no_overflow", overflow, 0);

    // Stalled consumer: only the first FIFO_DEPTH bytes survive.
    do_reset();
    send_frame(1'b0, 1056, 0, 1 << 30, 8);
    check_frame_end(1056);
    check_val("stall_overflow", overflow, 1);
    check_val("stall_valid", byte_valid, 1);
    drain();

    // Pop on the exact cycle a byte meets a full FIFO: nothing is lost.
    do_reset();
    send_frame(1'b0, 1056, 0, 71, 1000);
    check_frame_end(1056);
    drain();
    check_val("popfull_no_overflow", overflow, 0);

    // Strobe at bit 100: 12 bytes kept, restarted frame completes normally.
    do_reset();
    fd0 = fd_cnt;
    send_frame(1'b0, 100, 0, 0, 1000);
    check_val("pre_framing_err", framing_err, 0);
    check_val("partial_bit_count", bit_count, 100);
    send_frame(1'b0, 1056, 0, 0, 1000);
    check_val("framing_err_set", framing_err, 1);
    check_frame_end(1056);
    drain();
    check_val("restart_fd_count", fd_cnt - fd0, 1);
    check_val("restart_no_overflow", overflow, 0);

`ifdef RX_CHECKSUM_EN
    do_reset();
    send_frame(1'b0, 1056, 1, 0, 1000);
    check_val("checksum_zero", checksum, 8'h00);
    check_frame_end(1056);
    check_val("checksum_held", checksum, 8'h00);
    drain();
    send_frame(1'b0, 1056, 2, 0, 1000);
    check_val("checksum_ff", checksum, 8'hFF);
    check_frame_end(1056);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
